// File: rtl/csr_arb_pkg.sv
// Shared types for the CSR access arbiter: op codes, FSM states and
// the latched request bundle.
package csr_arb_pkg;

    localparam int unsigned CSR_ARB_XLEN = 64;
    localparam int unsigned CSR_ARB_AW   = 12;

    typedef enum logic [1:0] {
        CSR_RD  = 2'd0,
        CSR_WR  = 2'd1,
        CSR_SET = 2'd2,
        CSR_CLR = 2'd3
    } csr_arb_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } csr_arb_state_e;

    localparam logic OWNER_COMMIT = 1'b0;
    localparam logic OWNER_DBG    = 1'b1;

    typedef struct packed {
        logic [CSR_ARB_AW-1:0]   addr;
        csr_arb_op_e             op;
        logic [CSR_ARB_XLEN-1:0] wdata;
        logic                    owner;
    } csr_arb_req_t;

endpackage

// File: rtl/csr_rmw_alu.sv
// Write-data former for the write phase: plain write, set or clear
// against the value captured in the read phase.
module csr_rmw_alu
    import csr_arb_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  csr_arb_op_e     op,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = operand;
        unique case (op)
            CSR_RD:  result = operand;
            CSR_WR:  result = operand;
            CSR_SET: result = old_val | operand;
            CSR_CLR: result = old_val & ~operand;
        endcase
    end

endmodule

// File: rtl/csr_access_arbiter.sv
// Arbiter/sequencer for the single CSR port (commit vs debug), read then
// optional write. Optional starvation guard: CSR_ARB_STARVE_GUARD_EN.
module csr_access_arbiter
    import csr_arb_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            commit_valid_i,
    output logic            commit_ready_o,
    input  logic [11:0]     commit_addr_i,
    input  logic [1:0]      commit_op_i,
    input  logic [XLEN-1:0] commit_wdata_i,
    output logic            commit_rvalid_o,
    output logic            commit_err_o,
    input  logic            dbg_req_i,
    output logic            dbg_gnt_o,
    input  logic [11:0]     dbg_addr_i,
    input  logic [1:0]      dbg_op_i,
    input  logic [XLEN-1:0] dbg_wdata_i,
    output logic            dbg_rvalid_o,
    output logic            dbg_err_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            csr_req_o,
    output logic            csr_we_o,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    input  logic            csr_ack_i,
    input  logic [XLEN-1:0] csr_rdata_i,
    input  logic            csr_err_i
);

    csr_arb_state_e  state_q, state_d;
    csr_arb_req_t    req_q, req_d;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] alu_wdata;
    logic            err_q;
    logic            starve_hit;
    logic            commit_win;
    logic            dbg_win;
    logic            grant;

    // Grants are gated by reset so every output is low while it is held.
    assign commit_win = rst_ni & commit_valid_i & ~flush_i & ~starve_hit;
    assign dbg_win    = rst_ni & dbg_req_i & ~commit_win;
    assign grant      = (state_q == IDLE) & (commit_win | dbg_win);

    always_comb begin
        req_d = req_q;
        if (commit_win) begin
            req_d.addr  = commit_addr_i;
            req_d.op    = csr_arb_op_e'(commit_op_i);
            req_d.wdata = CSR_ARB_XLEN'(commit_wdata_i);
            req_d.owner = OWNER_COMMIT;
        end else begin
            req_d.addr  = dbg_addr_i;
            req_d.op    = csr_arb_op_e'(dbg_op_i);
            req_d.wdata = CSR_ARB_XLEN'(dbg_wdata_i);
            req_d.owner = OWNER_DBG;
        end
    end

`ifdef CSR_ARB_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
    logic [2:0] starve_q;

    assign starve_hit = dbg_req_i & (starve_q == STARVE_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else if (state_q == IDLE) begin
            if (dbg_win || !dbg_req_i) begin
                starve_q <= '0;
            end else if (commit_win && starve_q != STARVE_MAX) begin
                starve_q <= starve_q + 3'd1;
            end
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign starve_hit          = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant) state_d = READ;
            end
            READ: begin
                if (csr_ack_i) begin
                    if (csr_err_i || req_q.op == CSR_RD) state_d = RESP;
                    else                                 state_d = WRITE;
                end
            end
            WRITE: begin
                if (csr_ack_i) state_d = RESP;
            end
            RESP: state_d = IDLE;
        endcase
    end

    always_comb begin
        commit_ready_o  = 1'b0;
        dbg_gnt_o       = 1'b0;
        csr_req_o       = 1'b0;
        csr_we_o        = 1'b0;
        commit_rvalid_o = 1'b0;
        dbg_rvalid_o    = 1'b0;
        commit_err_o    = 1'b0;
        dbg_err_o       = 1'b0;
        unique case (state_q)
            IDLE: begin
                commit_ready_o = commit_win;
                dbg_gnt_o      = dbg_win;
            end
            READ: csr_req_o = 1'b1;
            WRITE: begin
                csr_req_o = 1'b1;
                csr_we_o  = 1'b1;
            end
            RESP: begin
                commit_rvalid_o = (req_q.owner == OWNER_COMMIT);
                dbg_rvalid_o    = (req_q.owner == OWNER_DBG);
                commit_err_o    = (req_q.owner == OWNER_COMMIT) & err_q;
                dbg_err_o       = (req_q.owner == OWNER_DBG) & err_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q   <= '0;
            old_q   <= '0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            if (grant) req_q <= req_d;
            if (state_q == READ && csr_ack_i) begin
                old_q <= csr_rdata_i;
                err_q <= csr_err_i;
            end
            if (state_q == WRITE) begin
                wdata_q <= alu_wdata;
                if (csr_ack_i) err_q <= csr_err_i;
            end
        end
    end

    csr_rmw_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .op     (req_q.op),
        .old_val(old_q),
        .operand(XLEN'(req_q.wdata)),
        .result (alu_wdata)
    );

    // Address and write data only move when a new phase needs them.
    assign csr_addr_o  = req_q.addr;
    assign csr_wdata_o = (state_q == WRITE) ? alu_wdata : wdata_q;
    assign rdata_o     = old_q;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Scoreboard bench for csr_access_arbiter: directed accesses against a
// small CSR-file responder with programmable wait states and errors.
module tb_csr_access_arbiter;
    import csr_arb_pkg::*;

    localparam int XLEN = 64;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic            commit_valid_i = 1'b0;
    logic            commit_ready_o;
    logic [11:0]     commit_addr_i = '0;
    logic [1:0]      commit_op_i = '0;
    logic [XLEN-1:0] commit_wdata_i = '0;
    logic            commit_rvalid_o;
    logic            commit_err_o;
    logic            dbg_req_i = 1'b0;
    logic            dbg_gnt_o;
    logic [11:0]     dbg_addr_i = '0;
    logic [1:0]      dbg_op_i = '0;
    logic [XLEN-1:0] dbg_wdata_i = '0;
    logic            dbg_rvalid_o;
    logic            dbg_err_o;
    logic [XLEN-1:0] rdata_o;
    logic            csr_req_o;
    logic            csr_we_o;
    logic [11:0]     csr_addr_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic            csr_ack_i = 1'b0;
    logic [XLEN-1:0] csr_rdata_i = '0;
    logic            csr_err_i = 1'b0;

    csr_access_arbiter #(
        .XLEN(XLEN),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .commit_valid_i(commit_valid_i), .commit_ready_o(commit_ready_o),
        .commit_addr_i(commit_addr_i), .commit_op_i(commit_op_i),
        .commit_wdata_i(commit_wdata_i), .commit_rvalid_o(commit_rvalid_o),
        .commit_err_o(commit_err_o),
        .dbg_req_i(dbg_req_i), .dbg_gnt_o(dbg_gnt_o),
        .dbg_addr_i(dbg_addr_i), .dbg_op_i(dbg_op_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_rvalid_o(dbg_rvalid_o),
        .dbg_err_o(dbg_err_o), .rdata_o(rdata_o),
        .csr_req_o(csr_req_o), .csr_we_o(csr_we_o),
        .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .csr_ack_i(csr_ack_i), .csr_rdata_i(csr_rdata_i),
        .csr_err_i(csr_err_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_pass = 0;
    int n_chk = 0;

    task automatic check(input bit ok, input string nm,
                         input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    typedef struct {
        bit          dbg;
        logic [63:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // CSR file responder
    int          delay = 0;
    logic [63:0] rd_value = '0;
    bit          err_rd = 1'b0;
    int          wait_cnt = 0;
    int          wr_count = 0;
    int          we_cycles = 0;
    logic [63:0] wr_data = '0;
    logic [11:0] wr_addr = '0;
    int          wr_cyc = -1;

    always @(negedge clk_i) begin
        if (!csr_req_o) begin
            csr_ack_i = 1'b0;
            csr_err_i = 1'b0;
            wait_cnt  = 0;
        end else begin
            if (csr_we_o) we_cycles++;
            if (wait_cnt < delay) begin
                csr_ack_i = 1'b0;
                wait_cnt++;
            end else begin
                csr_ack_i   = 1'b1;
                csr_rdata_i = rd_value;
                csr_err_i   = err_rd && !csr_we_o;
                wait_cnt    = 0;
                if (csr_we_o) begin
                    wr_count++;
                    wr_data = csr_wdata_o;
                    wr_addr = csr_addr_o;
                    wr_cyc  = cyc;
                end
            end
        end
    end

    // Response monitor
    always @(negedge clk_i) begin
        if (commit_rvalid_o || dbg_rvalid_o) begin
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_rvalid",
                      {62'd0, dbg_rvalid_o, commit_rvalid_o}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(dbg_rvalid_o == e.dbg && commit_rvalid_o == !e.dbg,
                      "resp_owner", {62'd0, dbg_rvalid_o, commit_rvalid_o},
                      {62'd0, e.dbg, !e.dbg});
                check(rdata_o == e.rdata, "resp_rdata", rdata_o, e.rdata);
                check((commit_err_o | dbg_err_o) == e.err, "resp_err",
                      64'(commit_err_o | dbg_err_o), 64'(e.err));
                check(cyc == e.cyc, "resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    function automatic bit outs_nonzero();
        return |{commit_ready_o, commit_rvalid_o, commit_err_o,
                 dbg_gnt_o, dbg_rvalid_o, dbg_err_o, csr_req_o,
                 csr_we_o, csr_addr_o, csr_wdata_o, rdata_o};
    endfunction

    task automatic issue(input bit dbg, input logic [11:0] a,
                         input logic [1:0] op, input logic [63:0] wd,
                         input int lat, input logic [63:0] exp_rd,
                         input bit exp_err, input bit push,
                         output int t);
        @(negedge clk_i);
        if (dbg) begin
            dbg_req_i = 1'b1; dbg_addr_i = a;
            dbg_op_i = op; dbg_wdata_i = wd;
        end else begin
            commit_valid_i = 1'b1; commit_addr_i = a;
            commit_op_i = op; commit_wdata_i = wd;
        end
        t = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (dbg ? dbg_gnt_o : commit_ready_o) begin
                t = cyc;
                break;
            end
            @(negedge clk_i);
        end
        check(t >= 0, "grant_seen", 64'(t), 64'd0);
        if (push && t >= 0)
            sb.push_back('{dbg: dbg, rdata: exp_rd, err: exp_err,
                           cyc: t + lat});
        @(posedge clk_i);
        #1;
        commit_valid_i = 1'b0;
        dbg_req_i = 1'b0;
    endtask

    task automatic wait_quiet(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            #1;
            if (sb.size() == 0 && !csr_req_o &&
                !commit_rvalid_o && !dbg_rvalid_o) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check(1'b0, nm, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t, w0, we0, nc, nd, run;
        bit found;
        int runs[$];

        repeat (3) @(negedge clk_i);
        #1;
        check(!outs_nonzero(), "reset_outputs", 64'(outs_nonzero()), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // zero-wait read
        rd_value = 64'hA;
        w0 = wr_count;
        issue(1'b0, 12'h300, CSR_RD, 64'h0, 2, 64'hA, 1'b0, 1'b1, t);
        @(negedge clk_i);
        check(csr_req_o && !csr_we_o && csr_addr_o == 12'h300,
              "rd_phase", {50'd0, csr_req_o, csr_we_o, csr_addr_o},
              {50'd0, 1'b1, 1'b0, 12'h300});
        wait_quiet("rd_quiet");
        check(wr_count == w0, "rd_no_write", 64'(wr_count), 64'(w0));

        // set: read-modify-write
        rd_value = 64'h3;
        issue(1'b0, 12'h300, CSR_SET, 64'h8, 3, 64'h3, 1'b0, 1'b1, t);
        wait_quiet("set_quiet");
        check(wr_data == 64'hB, "set_wdata", wr_data, 64'hB);
        check(wr_cyc == t + 2, "set_wcycle", 64'(wr_cyc), 64'(t + 2));
        check(wr_addr == 12'h300, "set_waddr", 64'(wr_addr), 64'h300);

        // debug clear, two wait states per phase
        delay = 2;
        rd_value = 64'hF;
        issue(1'b1, 12'h7B0, CSR_CLR, 64'h1, 7, 64'hF, 1'b0, 1'b1, t);
        wait_quiet("clr_quiet");
        check(wr_data == 64'hE, "clr_wdata", wr_data, 64'hE);
        check(wr_addr == 12'h7B0, "clr_waddr", 64'(wr_addr), 64'h7B0);
        delay = 0;

        // flush masks a commit grant in IDLE
        @(negedge clk_i);
        commit_valid_i = 1'b1; flush_i = 1'b1;
        commit_addr_i = 12'h301; commit_op_i = CSR_RD;
        #1;
        check(!commit_ready_o && !dbg_gnt_o, "flush_no_grant",
              {62'd0, commit_ready_o, dbg_gnt_o}, 64'd0);
        @(negedge clk_i);
        check(!csr_req_o, "flush_no_access", 64'(csr_req_o), 64'd0);
        commit_valid_i = 1'b0; flush_i = 1'b0;

        // flush during write does not abort
        rd_value = 64'h10;
        issue(1'b0, 12'h340, CSR_WR, 64'h77, 3, 64'h10, 1'b0, 1'b1, t);
        @(negedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        check(csr_we_o == 1'b1, "flush_we_phase", 64'(csr_we_o), 64'd1);
        @(negedge clk_i);
        flush_i = 1'b0;
        wait_quiet("flushwr_quiet");
        check(wr_data == 64'h77 && wr_cyc == t + 2, "flush_write_done",
              wr_data, 64'h77);

        // error in read phase suppresses the write
        rd_value = 64'h1234;
        err_rd = 1'b1;
        w0 = wr_count;
        we0 = we_cycles;
        issue(1'b0, 12'hFFF, CSR_WR, 64'h55, 2, 64'h1234, 1'b1, 1'b1, t);
        wait_quiet("err_quiet");
        check(wr_count == w0, "err_no_write", 64'(wr_count), 64'(w0));
        check(we_cycles == we0, "err_no_we", 64'(we_cycles), 64'(we0));
        err_rd = 1'b0;

        // both requesters held high
        rd_value = 64'h5A;
        commit_addr_i = 12'h001; commit_op_i = CSR_RD;
        dbg_addr_i = 12'h002; dbg_op_i = CSR_RD;
        commit_valid_i = 1'b1; dbg_req_i = 1'b1;
        nc = 0; nd = 0; run = 0;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clk_i);
            #1;
            if (commit_ready_o) begin
                nc++; run++;
                sb.push_back('{dbg: 1'b0, rdata: 64'h5A, err: 1'b0,
                               cyc: cyc + 2});
            end
            if (dbg_gnt_o) begin
                nd++;
                runs.push_back(run);
                run = 0;
                sb.push_back('{dbg: 1'b1, rdata: 64'h5A, err: 1'b0,
                               cyc: cyc + 2});
            end
            if (runs.size() >= 2) break;
        end
        @(posedge clk_i);
        #1;
        commit_valid_i = 1'b0; dbg_req_i = 1'b0;
`ifdef CSR_ARB_STARVE_GUARD_EN
        check(runs.size() >= 2, "starve_dbg_grants", 64'(runs.size()), 64'd2);
        if (runs.size() >= 2) begin
            check(runs[0] == 4, "starve_run0", 64'(runs[0]), 64'd4);
            check(runs[1] == 4, "starve_run1", 64'(runs[1]), 64'd4);
        end
`else
        check(nd == 0, "strict_no_dbg", 64'(nd), 64'd0);
        check(nc >= 10, "strict_commit_grants", 64'(nc), 64'd10);
`endif
        wait_quiet("starve_quiet");

        // reset in the middle of a write phase
        delay = 3;
        w0 = wr_count;
        issue(1'b0, 12'h305, CSR_WR, 64'hAA, 3, 64'h0, 1'b0, 1'b0, t);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            #1;
            if (csr_we_o) begin
                found = 1'b1;
                break;
            end
        end
        check(found, "rst_reach_write", 64'(found), 64'd1);
        rst_ni = 1'b0;
        #1;
        check(!outs_nonzero(), "rst_outputs_zero",
              64'(outs_nonzero()), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        delay = 0;
        repeat (8) @(negedge clk_i);
        #1;
        check(wr_count == w0, "rst_no_write", 64'(wr_count), 64'(w0));
        check(!csr_req_o, "rst_idle", 64'(csr_req_o), 64'd0);

        check(sb.size() == 0, "sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
